// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for an 8:1 mux with registered select and one-hot grant.
// Optional forced-release timeout is enabled by defining MUX_ARB_TIMEOUT_EN.
module mux_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  output logic [2:0] sel,
  output logic [7:0] grant,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {StIdle, StGrant, StGuard} state_e;

  state_e     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [2:0] last_q, last_d;
  logic [7:0] grant_q, grant_d;
  logic       busy_q, busy_d;
  logic       timeout_q, timeout_d;
  logic       win_found;
  logic [2:0] win_idx;

`ifdef MUX_ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
`else
  logic [7:0] unused_max_hold;
  assign unused_max_hold = 8'(MAX_HOLD);
`endif

  // Scan upward from last+1; i=8 wraps back to last itself, so it has lowest priority.
  always_comb begin
    logic [2:0] idx;
    idx       = '0;
    win_found = 1'b0;
    win_idx   = last_q;
    for (int i = 1; i <= 8; i++) begin
      idx = last_q + 3'(i);
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    last_d    = last_q;
    grant_d   = grant_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        grant_d = '0;
        busy_d  = 1'b0;
        if (win_found) begin
          state_d = StGrant;
          sel_d   = win_idx;
          last_d  = win_idx;
          grant_d = 8'b1 << win_idx;
          busy_d  = 1'b1;
`ifdef MUX_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      StGrant: begin
        if (!req[sel_q]) begin
          state_d = StGuard;
          grant_d = '0;
`ifdef MUX_ARB_TIMEOUT_EN
        end else if ((9'(cnt_q) + 9'd1) >= 9'(MAX_HOLD)) begin
          state_d   = StGuard;
          grant_d   = '0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
`endif
        end
      end
      StGuard: begin
        state_d = StIdle;
        grant_d = '0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      sel_q     <= '0;
      last_q    <= 3'd7;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
`ifdef MUX_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign sel     = sel_q;
  assign grant   = grant_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: stimulus pushes expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] req = '0;
  logic [2:0] sel;
  logic [7:0] grant;
  logic       busy;
  logic       timeout;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int tag = 0;

  typedef struct {
    int         cyc;
    int         tag;
    logic [7:0] g;
    logic [2:0] s;
    logic       b;
    logic       t;
  } exp_t;

  exp_t q[$];

  mux_rr_arbiter #(.MAX_HOLD(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .sel    (sel),
    .grant  (grant),
    .busy   (busy),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int id, input logic [7:0] g,
                       input logic [2:0] s, input logic b, input logic t);
    total++;
    if (grant !== g || sel !== s || busy !== b || timeout !== t) begin
      bad++;
      $display("FAIL %s#%0d: got grant=%h sel=%0d busy=%b timeout=%b, want grant=%h sel=%0d busy=%b timeout=%b",
               name, id, grant, sel, busy, timeout, g, s, b, t);
    end
  endtask

  // Monitor: compare every expectation whose target cycle has arrived.
  always @(negedge clk) begin
    while (q.size() != 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      check("step", e.tag, e.g, e.s, e.b, e.t);
    end
    if (grant != 8'h00) begin
      total++;
      if (!$onehot(grant) || !grant[sel]) begin
        bad++;
        $display("FAIL onehot: grant=%h sel=%0d", grant, sel);
      end
    end
  end

  // Drive req for the coming edge and record the outputs expected after it.
  task automatic drive(input logic [7:0] r, input logic [7:0] g, input logic [2:0] s,
                       input logic b, input logic t);
    exp_t e;
    @(posedge clk);
    #1;
    req   = r;
    e.cyc = cyc + 1;
    e.tag = tag;
    e.g   = g;
    e.s   = s;
    e.b   = b;
    e.t   = t;
    q.push_back(e);
    tag++;
  endtask

  task automatic drain();
    for (int k = 0; k < 50 && q.size() != 0; k++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
      q.delete();
    end
  endtask

  // Asynchronous reset mid-cycle, checked before any clock edge occurs.
  task automatic do_reset(input logic [7:0] r_after);
    drain();
    reset = 1'b1;
    #1;
    check("async_reset", tag, 8'h00, 3'd0, 1'b0, 1'b0);
    req = r_after;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] m;
    logic [2:0] ch;
    #7;
    check("reset_state", 0, 8'h00, 3'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single requester, held 3 cycles then dropped.
    drive(8'h01, 8'h01, 3'd0, 1'b1, 1'b0);
    drive(8'h01, 8'h01, 3'd0, 1'b1, 1'b0);
    drive(8'h01, 8'h01, 3'd0, 1'b1, 1'b0);
    drive(8'h00, 8'h00, 3'd0, 1'b1, 1'b0);
    drive(8'h00, 8'h00, 3'd0, 1'b0, 1'b0);

    // All requesting: rotation 0..7 then back to 0.
    do_reset(8'h00);
    for (int i = 0; i < 9; i++) begin
      ch = 3'(i % 8);
      m  = 8'h01 << ch;
      drive(8'hFF, m, ch, 1'b1, 1'b0);
      drive(8'hFF, m, ch, 1'b1, 1'b0);
      drive(8'hFF & ~m, 8'h00, ch, 1'b1, 1'b0);
      drive(8'hFF, 8'h00, ch, 1'b0, 1'b0);
    end

    // Wrap-around between channels 0 and 7.
    do_reset(8'h00);
    drive(8'h81, 8'h01, 3'd0, 1'b1, 1'b0);
    drive(8'h81, 8'h01, 3'd0, 1'b1, 1'b0);
    drive(8'h80, 8'h00, 3'd0, 1'b1, 1'b0);
    drive(8'h81, 8'h00, 3'd0, 1'b0, 1'b0);
    drive(8'h81, 8'h80, 3'd7, 1'b1, 1'b0);
    drive(8'h81, 8'h80, 3'd7, 1'b1, 1'b0);
    drive(8'h01, 8'h00, 3'd7, 1'b1, 1'b0);
    drive(8'h81, 8'h00, 3'd7, 1'b0, 1'b0);
    drive(8'h81, 8'h01, 3'd0, 1'b1, 1'b0);
    drive(8'h00, 8'h00, 3'd0, 1'b1, 1'b0);
    drive(8'h00, 8'h00, 3'd0, 1'b0, 1'b0);

    // Owner 3 holds while channel 4 also requests.
    do_reset(8'h00);
    drive(8'h08, 8'h08, 3'd3, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(8'h18, 8'h08, 3'd3, 1'b1, 1'b0);
    drive(8'h10, 8'h00, 3'd3, 1'b1, 1'b0);
    drive(8'h10, 8'h00, 3'd3, 1'b0, 1'b0);
    drive(8'h10, 8'h10, 3'd4, 1'b1, 1'b0);
    drive(8'h00, 8'h00, 3'd4, 1'b1, 1'b0);
    drive(8'h00, 8'h00, 3'd4, 1'b0, 1'b0);

    // Reset in the middle of a grant to channel 5.
    do_reset(8'h00);
    drive(8'h20, 8'h20, 3'd5, 1'b1, 1'b0);
    drive(8'h20, 8'h20, 3'd5, 1'b1, 1'b0);
    do_reset(8'h21);
    drive(8'h21, 8'h01, 3'd0, 1'b1, 1'b0);
    drive(8'h20, 8'h00, 3'd0, 1'b1, 1'b0);
    drive(8'h21, 8'h00, 3'd0, 1'b0, 1'b0);
    drive(8'h21, 8'h20, 3'd5, 1'b1, 1'b0);
    drive(8'h00, 8'h00, 3'd5, 1'b1, 1'b0);
    drive(8'h00, 8'h00, 3'd5, 1'b0, 1'b0);

`ifdef MUX_ARB_TIMEOUT_EN
    // Forced release after 4 cycles, then a drop coinciding with the limit.
    do_reset(8'h00);
    for (int i = 0; i < 4; i++) drive(8'h04, 8'h04, 3'd2, 1'b1, 1'b0);
    drive(8'h04, 8'h00, 3'd2, 1'b1, 1'b1);
    drive(8'h04, 8'h00, 3'd2, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive(8'h04, 8'h04, 3'd2, 1'b1, 1'b0);
    drive(8'h00, 8'h00, 3'd2, 1'b1, 1'b0);
    drive(8'h00, 8'h00, 3'd2, 1'b0, 1'b0);
`endif

    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
